// File: rtl/dhcp_led_status.sv
// rtl/dhcp_led_status.sv - link/DHCP progress tracker driving the LED flasher control triple
module dhcp_led_status #(
    parameter logic [7:0]  DIV_SLOW       = 8'd200,
    parameter logic [7:0]  DIV_FAST       = 8'd50,
    parameter logic [7:0]  DIV_FAULT      = 8'd10,
    parameter logic [7:0]  DIV_ACT        = 8'd25,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd125000000,
    parameter logic [31:0] FAULT_HOLD     = 32'd250000000,
    parameter logic [23:0] ACT_CYCLES     = 24'd6250000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_link_up,
    input  logic       i_dhcp_discover,
    input  logic       i_dhcp_offer,
    input  logic       i_dhcp_ack,
    input  logic       i_dhcp_nak,
    input  logic       i_lease_expire,
    input  logic       i_rx_pkt,
    output logic       o_led_on,
    output logic       o_led_flash,
    output logic [7:0] o_divider,
    output logic [2:0] o_state,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        S_LINK_DOWN  = 3'd0,
        S_IDLE       = 3'd1,
        S_SELECTING  = 3'd2,
        S_REQUESTING = 3'd3,
        S_BOUND      = 3'd4,
        S_FAULT      = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] fault_cnt_q, fault_cnt_d;
    logic [23:0] act_cnt_q, act_cnt_d;
    logic        act_flag_q, act_flag_d;
    logic        led_on_q, led_on_d;
    logic        led_flash_q, led_flash_d;
    logic [7:0]  divider_q, divider_d;
    logic        timeout_q, timeout_d;
    logic        in_neg_q, in_neg_d;

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        in_neg_q  = (state_q == S_SELECTING) || (state_q == S_REQUESTING);

        // Priority chain: earlier branches win when events coincide.
        if (!i_link_up || (state_q > S_FAULT)) begin
            state_d = S_LINK_DOWN;
        end else if (state_q == S_LINK_DOWN) begin
            state_d = S_IDLE;
        end else if ((state_q == S_BOUND) && i_lease_expire) begin
            state_d = S_IDLE;
        end else if (((state_q == S_REQUESTING) || (state_q == S_BOUND)) && i_dhcp_nak) begin
            state_d = S_FAULT;
        end else if ((state_q == S_REQUESTING) && i_dhcp_ack) begin
            state_d = S_BOUND;
        end else if ((state_q == S_SELECTING) && i_dhcp_offer) begin
            state_d = S_REQUESTING;
        end else if (((state_q == S_IDLE) || (state_q == S_FAULT)) && i_dhcp_discover) begin
            state_d = S_SELECTING;
        end else if (in_neg_q && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1)) begin
            state_d   = S_FAULT;
            timeout_d = 1'b1;
        end else if ((state_q == S_FAULT) && (fault_cnt_q == FAULT_HOLD - 32'd1)) begin
            state_d = S_IDLE;
        end

        // One timeout budget spans SELECTING and REQUESTING together.
        in_neg_d = (state_d == S_SELECTING) || (state_d == S_REQUESTING);
        if (in_neg_d && !((state_d == S_SELECTING) && (state_q != S_SELECTING))) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_d = 32'd0;
        end

        if ((state_d == S_FAULT) && (state_q == S_FAULT)) begin
            fault_cnt_d = (fault_cnt_q == 32'hFFFF_FFFF) ? fault_cnt_q : fault_cnt_q + 32'd1;
        end else begin
            fault_cnt_d = 32'd0;
        end

        act_cnt_d  = act_cnt_q;
        act_flag_d = act_flag_q;
        if ((state_d != S_BOUND) || (state_q != S_BOUND)) begin
            act_cnt_d  = 24'd0;
            act_flag_d = 1'b0;
        end else if (i_rx_pkt) begin
            act_cnt_d  = ACT_CYCLES - 24'd1;
            act_flag_d = 1'b1;
        end else if (act_flag_q) begin
            if (act_cnt_q == 24'd0) begin
                act_flag_d = 1'b0;
            end else begin
                act_cnt_d = act_cnt_q - 24'd1;
            end
        end

        // Divider holds its last value whenever the LED is not flashing.
        led_on_d    = (state_d != S_LINK_DOWN);
        led_flash_d = 1'b0;
        divider_d   = divider_q;
        case (state_d)
            S_IDLE: begin
                led_flash_d = 1'b1;
                divider_d   = DIV_SLOW;
            end
            S_SELECTING, S_REQUESTING: begin
                led_flash_d = 1'b1;
                divider_d   = DIV_FAST;
            end
            S_BOUND: begin
                if (act_flag_d) begin
                    led_flash_d = 1'b1;
                    divider_d   = DIV_ACT;
                end
            end
            S_FAULT: begin
                led_flash_d = 1'b1;
                divider_d   = DIV_FAULT;
            end
            default: begin
                led_flash_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_LINK_DOWN;
            tmo_cnt_q   <= 32'd0;
            fault_cnt_q <= 32'd0;
            act_cnt_q   <= 24'd0;
            act_flag_q  <= 1'b0;
            led_on_q    <= 1'b0;
            led_flash_q <= 1'b0;
            divider_q   <= DIV_SLOW;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            act_cnt_q   <= act_cnt_d;
            act_flag_q  <= act_flag_d;
            led_on_q    <= led_on_d;
            led_flash_q <= led_flash_d;
            divider_q   <= divider_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_state     = state_q;
    assign o_led_on    = led_on_q;
    assign o_led_flash = led_flash_q;
    assign o_divider   = divider_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_dhcp_led_status.sv
// tb/tb_dhcp_led_status.sv - randomized and directed check of dhcp_led_status against a timestamp model
module tb_dhcp_led_status;

    localparam int T_OUT = 100;
    localparam int F_HLD = 50;
    localparam int A_LEN = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       link_up = 1'b0;
    logic       discover = 1'b0, offer = 1'b0, ack = 1'b0, nak = 1'b0, expire = 1'b0, rx = 1'b0;
    logic       led_on, led_flash, timeout;
    logic [7:0] divider;
    logic [2:0] state;

    int n_pass = 0;
    int n_total = 0;

    int m_st, m_on, m_flash, m_div, m_tmo;
    int cyc, neg_start, fault_start, act_end;

    dhcp_led_status #(
        .TIMEOUT_CYCLES(32'd100),
        .FAULT_HOLD    (32'd50),
        .ACT_CYCLES    (24'd20)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_link_up      (link_up),
        .i_dhcp_discover(discover),
        .i_dhcp_offer   (offer),
        .i_dhcp_ack     (ack),
        .i_dhcp_nak     (nak),
        .i_lease_expire (expire),
        .i_rx_pkt       (rx),
        .o_led_on       (led_on),
        .o_led_flash    (led_flash),
        .o_divider      (divider),
        .o_state        (state),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_on = 0; m_flash = 0; m_div = 200; m_tmo = 0; act_end = 0;
    endtask

    // State codes: 0 link down, 1 idle, 2 selecting, 3 requesting, 4 bound, 5 fault.
    // Timers are kept as entry timestamps on the edge count.
    task automatic model_step();
        int ns;
        bit active;
        cyc++;
        ns = m_st;
        m_tmo = 0;
        if (!link_up) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st == 4 && expire) ns = 1;
        else if ((m_st == 3 || m_st == 4) && nak) ns = 5;
        else if (m_st == 3 && ack) ns = 4;
        else if (m_st == 2 && offer) ns = 3;
        else if ((m_st == 1 || m_st == 5) && discover) ns = 2;
        else if ((m_st == 2 || m_st == 3) && (cyc - neg_start == T_OUT)) begin ns = 5; m_tmo = 1; end
        else if (m_st == 5 && (cyc - fault_start == F_HLD)) ns = 1;

        if (ns == 2 && m_st != 2) neg_start = cyc;
        if (ns == 5 && m_st != 5) fault_start = cyc;
        if (ns != 4) act_end = 0;
        else if (m_st == 4 && rx) act_end = cyc + A_LEN;
        active = (ns == 4) && (cyc < act_end);

        m_on = (ns != 0);
        m_flash = (ns == 1 || ns == 2 || ns == 3 || ns == 5 || active) ? 1 : 0;
        if (m_flash) begin
            case (ns)
                1: m_div = 200;
                2, 3: m_div = 50;
                4: m_div = 25;
                default: m_div = 10;
            endcase
        end
        m_st = ns;
    endtask

    task automatic check_all();
        chk("state", state, m_st);
        chk("led_on", led_on, m_on);
        chk("led_flash", led_flash, m_flash);
        chk("divider", divider, m_div);
        chk("timeout", timeout, m_tmo);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_all();
        discover = 0; offer = 0; ack = 0; nak = 0; expire = 0; rx = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        cyc = 0; neg_start = 0; fault_start = 0;
        model_reset();
        ticks(2);
        #3 rst_n = 1;
        ticks(10);
        chk("ld_state", state, 0);
        chk("ld_on", led_on, 0);
        link_up = 1; tick();
        chk("idle_state", state, 1);
        chk("idle_div", divider, 200);

        discover = 1; tick(); chk("sel_state", state, 2);
        ticks(4);
        offer = 1; tick(); chk("req_state", state, 3);
        ticks(4);
        ack = 1; tick(); chk("bound_state", state, 4); chk("bound_flash", led_flash, 0);

        rx = 1; tick(); chk("act_div", divider, 25);
        ticks(9);
        rx = 1; tick();
        ticks(19); chk("act_last", led_flash, 1);
        tick(); chk("act_end", led_flash, 0);
        rx = 1; tick(); ticks(3);
        nak = 1; tick(); chk("nak_fault", state, 5); chk("nak_div", divider, 10);
        ticks(49); chk("hold_fault", state, 5);
        tick(); chk("hold_idle", state, 1);

        discover = 1; tick();
        ticks(99); chk("pre_tmo_state", state, 2); chk("pre_tmo", timeout, 0);
        tick(); chk("tmo_pulse", timeout, 1); chk("tmo_state", state, 5);
        tick(); chk("tmo_once", timeout, 0);
        ticks(48); tick(); chk("tmo_hold_idle", state, 1);

        discover = 1; tick(); offer = 1; tick();
        ack = 1; link_up = 0; tick(); chk("link_wins", state, 0);
        link_up = 1; tick();
        discover = 1; tick(); offer = 1; tick(); ack = 1; tick();
        expire = 1; nak = 1; tick(); chk("expire_wins", state, 1);

        discover = 1; tick(); offer = 1; tick(); ack = 1; tick();
        rx = 1; tick(); ticks(5);
        #2 rst_n = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_flash", led_flash, 0);
        chk("arst_div", divider, 200);
        chk("arst_on", led_on, 0);
        model_reset();
        ticks(2);
        #3 rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            if (link_up) link_up = ($urandom_range(0, 99) != 0);
            else link_up = ($urandom_range(0, 3) == 0);
            discover = ($urandom_range(0, 19) == 0);
            offer    = ($urandom_range(0, 19) == 0);
            ack      = ($urandom_range(0, 19) == 0);
            nak      = ($urandom_range(0, 59) == 0);
            expire   = ($urandom_range(0, 79) == 0);
            rx       = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dhcp_led_status.md
Name: dhcp_led_status

Overview:
- Upstream driver for the LED flasher stage: tracks link and DHCP client progress from single-cycle event pulses.
- Converts that progress into the flasher's control triple: steady-on, flash enable and flash-rate divider.
- Adds a packet-activity stretch while a lease is held.
- Sits between the DHCP client engine/MAC status and the per-LED flasher instance.

Parameters:
- DIV_SLOW, 8'd200, divider output while link is up and no lease is held (IDLE).
- DIV_FAST, 8'd50, divider output during SELECTING/REQUESTING.
- DIV_FAULT, 8'd10, divider output in FAULT.
- DIV_ACT, 8'd25, divider output during an activity stretch in BOUND.
- TIMEOUT_CYCLES, 32'd125000000, cycles allowed in SELECTING+REQUESTING before FAULT.
- FAULT_HOLD, 32'd250000000, cycles held in FAULT before auto-return to IDLE.
- ACT_CYCLES, 24'd6250000, activity stretch length in BOUND.

Ports:
- i_clk  input  1  system clock; all logic in this domain.
- i_rst_n  input  1  asynchronous active-low reset.
- i_link_up  input  1  PHY link level, already synchronous to i_clk.
- i_dhcp_discover  input  1  pulse: DISCOVER transmitted.
- i_dhcp_offer  input  1  pulse: valid OFFER received.
- i_dhcp_ack  input  1  pulse: ACK received.
- i_dhcp_nak  input  1  pulse: NAK received.
- i_lease_expire  input  1  pulse: lease timer expired.
- i_rx_pkt  input  1  pulse: frame received for this host.
- o_led_on  output  1  to flasher i_led_on.
- o_led_flash  output  1  to flasher i_led_flash.
- o_divider  output  8  to flasher i_divider.
- o_state  output  3  current state code, for debug/CSR.
- o_timeout  output  1  one-cycle pulse when the negotiation timeout fires.

Behaviour:
- Reset (async assert, sync release):
  - state=LINK_DOWN; o_led_on=0, o_led_flash=0, o_divider=DIV_SLOW, o_state=0, o_timeout=0.
  - All counters cleared.
- States (encoding in brackets):
  - LINK_DOWN(0), IDLE(1), SELECTING(2), REQUESTING(3), BOUND(4), FAULT(5).
  - Codes 6-7 are unreachable; if entered, go to LINK_DOWN next cycle.
- Transition priority, highest first, evaluated every cycle:
  1. i_link_up=0 -> LINK_DOWN from any state.
  2. LINK_DOWN with i_link_up=1 -> IDLE.
  3. i_lease_expire in BOUND -> IDLE.
  4. i_dhcp_nak in REQUESTING or BOUND -> FAULT.
  5. i_dhcp_ack in REQUESTING -> BOUND.
  6. i_dhcp_offer in SELECTING -> REQUESTING.
  7. i_dhcp_discover in IDLE or FAULT -> SELECTING.
  8. Timeout counter reaches TIMEOUT_CYCLES-1 in SELECTING/REQUESTING -> FAULT, with o_timeout=1 for exactly one cycle.
  9. FAULT hold counter reaches FAULT_HOLD-1 -> IDLE.
- Events not listed for the current state are ignored.
- Simultaneous events resolve by the priority order above.
- Timing and counters:
  - State change is visible on o_state one cycle after the event pulse.
  - Timeout counter clears on entry to SELECTING from any other state and does not clear on SELECTING->REQUESTING (one budget covers the whole negotiation). It is held at 0 outside those two states.
  - Fault counter clears on FAULT entry and saturates; it never wraps.
- Output decode:
  - Outputs are registered from next-state, so they change on the same edge as o_state.
  - LINK_DOWN: on=0, flash=0.
  - IDLE: on=1, flash=1, div=DIV_SLOW.
  - SELECTING/REQUESTING: on=1, flash=1, div=DIV_FAST.
  - BOUND: on=1, flash=0, except during an activity stretch: flash=1, div=DIV_ACT.
  - FAULT: on=1, flash=1, div=DIV_FAULT.
  - o_divider keeps its previous value in states where flash=0.
- Activity stretch (BOUND only):
  - i_rx_pkt loads the stretch counter with ACT_CYCLES-1 and sets the stretch flag.
  - The counter counts down to 0, then clears the flag.
  - A new i_rx_pkt mid-stretch reloads the counter (retrigger).
  - Leaving BOUND clears the counter and flag immediately.
  - i_rx_pkt outside BOUND is ignored.
- Reset mid-operation returns to the reset values immediately, regardless of state or counters.

Test Plan (TIMEOUT_CYCLES=100, FAULT_HOLD=50, ACT_CYCLES=20):
- Reset, link_up=0 for 10 cycles -> o_state=0, on=0, flash=0; raise link_up -> next cycle o_state=1, on=1, flash=1, div=200.
- From IDLE, pulse discover, then offer 5 cycles later, then ack 5 cycles later -> states 2, 3, 4, each one cycle after its pulse; BOUND gives on=1, flash=0.
- From IDLE, pulse discover, send no offer -> exactly 100 cycles after SELECTING entry: o_timeout=1 for one cycle, o_state=5, div=10; 50 cycles later o_state=1.
- In BOUND, pulse rx_pkt, then again at +10 -> flash=1, div=25 for 30 cycles total, then flash=0; during stretch pulse nak -> FAULT next cycle, stretch cleared.
- In REQUESTING, pulse ack and link_up=0 in the same cycle -> o_state=0 (link down wins); in BOUND, lease_expire and nak in the same cycle -> o_state=1.
- Assert i_rst_n low mid-stretch in BOUND -> outputs at reset values with no clock edge required.
